// File: rtl/result_mux_pipe.sv
// result_mux_pipe: two-stage valid/ready pipelined N:1 result selector (4:1 per group, then group select)
module result_mux_pipe #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_BITS-1:0]              cntrl,
  input  logic [(2**SEL_BITS)*WIDTH-1:0]   results,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out,
  output logic [SEL_BITS-1:0]              out_sel
);
  localparam int N = 2**SEL_BITS;
  localparam int G = N/4;
  logic                  s1_valid, s1_adv, s2_adv;
  logic [SEL_BITS-1:0]   s1_sel;
  logic [G*WIDTH-1:0]    part, s1_part;
  logic [WIDTH-1:0]      pick;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  for (genvar g = 0; g < G; g++) begin : grp
    assign part[g*WIDTH +: WIDTH] = results[(4*g + cntrl[1:0])*WIDTH +: WIDTH];
  end
  if (SEL_BITS > 2) begin : hi
    assign pick = s1_part[s1_sel[SEL_BITS-1:2]*WIDTH +: WIDTH];
  end else begin : lo
    assign pick = s1_part;
  end
  always_ff @(posedge clk) begin
    if (!reset && s1_adv && in_valid) begin
      s1_part <= part;
      s1_sel  <= cntrl;
    end
  end
  // out only loads on a real transaction, so a bubble leaves it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sel   <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out     <= pick;
        out_sel <= s1_sel;
      end
    end
  end
endmodule

// File: tb/tb_result_mux_pipe.sv
// tb_result_mux_pipe: table-driven cycle checks plus scoreboards on a main DUT and four parameter-sweep DUTs
module tb_result_mux_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] cand(input int k);
    return 64'h1111_0000_0000_0000 * 64'(k + 1) + 64'(k);
  endfunction
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    cntrl, out_sel;
  logic [511:0]  results;
  logic [63:0]   out;
  result_mux_pipe #(.WIDTH(64), .SEL_BITS(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .cntrl(cntrl),
    .results(results), .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_sel(out_sel)
  );
  typedef struct { logic [63:0] d; logic [2:0] s; } m_t;
  m_t mq[$];
  m_t me;
  always @(negedge clk) begin
    if (reset) mq.delete();
    else begin
      if (out_valid && out_ready) begin
        chk("main_occupied", 64'(mq.size() != 0), 64'd1);
        if (mq.size() != 0) begin
          me = mq.pop_front();
          chk("main_sb_out", out, me.d);
          chk("main_sb_sel", 64'(out_sel), 64'(me.s));
        end
      end
      if (in_valid && in_ready) mq.push_back('{results[cntrl*64 +: 64], cntrl});
    end
  end
  typedef struct {
    logic iv; logic [2:0] c; logic ordy;
    logic e_ir; logic e_ov; logic [63:0] e_out; logic [2:0] e_sel;
  } vec_t;
  function automatic vec_t mk(input logic iv, input int c, input logic o, input logic eir, input logic eov, input int k);
    return '{iv, 3'(c), o, eir, eov, cand(k), 3'(k)};
  endfunction
  vec_t tab[24];
  logic [3:0] all_done;
  for (genvar c = 0; c < 4; c++) begin : sw
    localparam int SB = (c % 2) ? 6 : 2;
    localparam int W  = (c / 2) ? 64 : 1;
    localparam int SN = 2**SB;
    logic rs, iv, ir, ov, ordy, done;
    logic [SB-1:0]   cn, osel;
    logic [SN*W-1:0] res;
    logic [W-1:0]    o;
    typedef struct { logic [W-1:0] d; logic [SB-1:0] s; } exp_t;
    exp_t q[$];
    exp_t e;
    result_mux_pipe #(.WIDTH(W), .SEL_BITS(SB)) dut (
      .clk(clk), .reset(rs), .in_valid(iv), .in_ready(ir), .cntrl(cn),
      .results(res), .out_valid(ov), .out_ready(ordy), .out(o), .out_sel(osel)
    );
    assign all_done[c] = done;
    initial begin
      rs = 1'b1; iv = 1'b0; ordy = 1'b0; cn = '0; res = '0; done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rs = 1'b0;
      for (int i = 0; i < 300; i++) begin
        iv = 1'($urandom_range(0, 1));
        cn = SB'($urandom);
        for (int b = 0; b < SN*W; b++) res[b] = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      iv = 1'b0;
      ordy = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sw%0d_drain", c), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
    always @(negedge clk) begin
      if (rs) q.delete();
      else begin
        if (ov && ordy) begin
          chk($sformatf("sw%0d_occupied", c), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("sw%0d_out", c), 64'(o), 64'(e.d));
            chk($sformatf("sw%0d_sel", c), 64'(osel), 64'(e.s));
          end
        end
        if (iv && ir) q.push_back('{res[cn*W +: W], cn});
      end
    end
  end
  initial begin
    tab[0] = mk(1, 5, 1, 1, 0, 0);
    tab[1] = mk(0, 0, 1, 1, 0, 0);
    tab[2] = mk(0, 0, 1, 1, 1, 5);
    tab[3] = mk(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++)
      tab[4+i] = mk(i < 8, i % 8, 1, 1, (i >= 2) && (i < 10), (i >= 2 && i < 10) ? i - 2 : 0);
    tab[15] = mk(1, 2, 0, 1, 0, 0);
    tab[16] = mk(1, 6, 0, 1, 0, 0);
    tab[17] = mk(1, 7, 0, 0, 1, 2);
    tab[18] = mk(1, 3, 0, 0, 1, 2);
    tab[19] = mk(1, 7, 1, 1, 1, 2);
    tab[20] = mk(0, 0, 0, 0, 1, 6);
    tab[21] = mk(0, 0, 1, 1, 1, 6);
    tab[22] = mk(0, 0, 1, 1, 1, 7);
    tab[23] = mk(0, 0, 1, 1, 0, 0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cntrl = '0;
    for (int k = 0; k < 8; k++) results[k*64 +: 64] = cand(k);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      in_valid = tab[i].iv;
      cntrl = tab[i].c;
      out_ready = tab[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tab[i].e_ir));
      chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tab[i].e_ov));
      if (tab[i].e_ov) begin
        chk($sformatf("row%0d_out", i), out, tab[i].e_out);
        chk($sformatf("row%0d_out_sel", i), 64'(out_sel), 64'(tab[i].e_sel));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1; cntrl = 3'd1; out_ready = 1'b0;
    @(posedge clk);
    #1 cntrl = 3'd4;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_out", out, cand(1));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b1; cntrl = 3'd3; out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", out, 64'd0);
    chk("midrst_out_sel", 64'(out_sel), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("postrst%0d_out_valid", i), 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b1; cntrl = 3'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 600 && all_done != 4'hf; i++) @(posedge clk);
    chk("sweep_done", 64'(all_done), 64'hf);
    @(negedge clk);
    chk("main_drain", 64'(mq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_mux_pipe.md
RESULT_MUX_PIPE -- requirements
Module: result_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of each candidate result and of the output.
REQ-002 SHALL have parameter SEL_BITS, default 3, select width; number of candidates N = 2**SEL_BITS; legal range 2..6.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers a (cntrl, results) transaction.
REQ-006 SHALL have port in_ready  output  1  block accepts the offered transaction this cycle.
REQ-007 SHALL have port cntrl  input  SEL_BITS  index of the candidate to forward.
REQ-008 SHALL have port results  input  N*WIDTH  packed candidates; candidate k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid  output  1  out holds a valid selected result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out this cycle.
REQ-011 SHALL have port out  output  WIDTH  selected result.
REQ-012 SHALL have port out_sel  output  SEL_BITS  the cntrl value that produced out.

Function
REQ-013 SHALL be a two-stage pipeline: stage 1 (S1) and stage 2 (S2), each with its own valid bit.
REQ-014 S1 SHALL split the N candidates into N/4 groups of 4 consecutive candidates, select one per group using cntrl[1:0], and register the N/4 partial results plus cntrl[SEL_BITS-1:2] and the full cntrl.
REQ-015 S2 SHALL select among the registered partials using the registered cntrl[SEL_BITS-1:2], and register the result into out and the full cntrl into out_sel.
REQ-016 Functional result SHALL equal candidate cntrl of the accepted transaction, bit-exact, with no truncation or extension.
REQ-017 Transfer SHALL occur on input when in_valid && in_ready and on output when out_valid && out_ready.
REQ-018 s2_adv SHALL be !out_valid || out_ready; s1_adv SHALL be !s1_valid || s2_adv; in_ready SHALL equal s1_adv, combinationally, with no dependence on in_valid.
REQ-019 When s1_adv, S1 SHALL load on in_valid and set s1_valid = in_valid; otherwise S1 SHALL hold.
REQ-020 When s2_adv, S2 SHALL load from S1 and set out_valid = s1_valid; otherwise out, out_sel, and out_valid SHALL hold unchanged.
REQ-021 Minimum latency SHALL be 2 cycles from input transfer to out_valid; sustained throughput SHALL be 1 transaction per cycle while out_ready = 1.
REQ-022 With out_ready = 0 and both stages full, in_ready SHALL be 0; the block SHALL hold at most 2 transactions and never drop or duplicate one.
REQ-023 Simultaneous output transfer and input transfer in the same cycle with both stages full SHALL shift the pipeline by one with no bubble.
REQ-024 Transactions SHALL exit in acceptance order.
REQ-025 Data registers SHALL load only on an advancing valid transaction; a bubble SHALL not overwrite out while out_valid = 0 is being set, and out_valid SHALL fall to 0.
REQ-026 cntrl and results SHALL be sampled only on input transfer; changes while in_ready = 0 SHALL have no effect.

Reset
REQ-027 When reset is 1 at a rising edge, s1_valid and out_valid SHALL become 0, and out and out_sel SHALL become all-zero.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; no transaction accepted before the reset SHALL appear at the output afterwards.
REQ-029 in_ready SHALL be 1 during the first cycle after reset deasserts.
REQ-030 Reset SHALL take priority over any simultaneous transfer.

Verification
REQ-031 Reset, then with WIDTH=64, SEL_BITS=3, results[k] = 64'h1111_0000_0000_0000*(k+1)+k, cntrl=5, one-cycle in_valid, and out_ready=1: out_valid rises exactly 2 cycles later, out = results[5], and out_sel = 5.
REQ-032 Streaming cntrl = 0,1,...,7 on consecutive cycles with out_ready=1: outputs are results[0]..results[7] on 8 consecutive cycles, and in_ready is 1 throughout.
REQ-033 Backpressure: out_ready=0 while 3 transactions are offered (cntrl 2,6,7): in_ready falls after 2 are accepted and out holds results[2] stable; releasing out_ready yields 2, 6, 7 in order with none lost.
REQ-034 Full pipeline with out_ready=1 and in_valid=1 in the same cycle: one out and one in transfer occur, and occupancy stays 2.
REQ-035 Assert reset while both stages are full: out_valid=0, out=0, out_sel=0 the next cycle, and no pre-reset data is ever emitted.
REQ-036 Parameter sweep SEL_BITS=2 (N=4) and SEL_BITS=6 (N=64), WIDTH=1 and WIDTH=64, with random cntrl/results and random out_ready: every output equals its reference candidate, in order.
